// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM state type.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath shared by unsigned shift-add multiply and restoring divide,
// one bit per step, WIDTH steps per operation.
module alu_seq_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     quotient,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);

  // acc is {high, low}: for MUL {partial sum, multiplier}, for DIV {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               div_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mul_sum, div_win, div_diff;
  logic               div_ge;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_win  = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_win >= {1'b0, opnd});
    div_diff = div_win - {1'b0, opnd};
    if (div_q)
      acc_nxt = {(div_ge ? div_diff[WIDTH-1:0] : div_win[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    else
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, (div ? a : b)};
      opnd  <= div ? b : a;
      div_q <= div;
      cnt   <= '0;
    end else if (step) begin
      acc   <= acc_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

  assign product  = acc;
  assign quotient = acc[WIDTH-1:0];
  assign last     = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: accepts one operation from IDLE, runs MUL/DIV iteratively,
// and registers the result and flags in FINISH with a one-cycle done pulse.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic               accept, iter_load, iter_step, iter_last;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient;

  logic [WIDTH-1:0]   r;
  logic               c, v;
  logic [WIDTH:0]     add_s, sub_d, shl_w, shr_w;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [SHW-1:0]     sh_n;

  // The done cycle still counts as busy, so a start there is dropped.
  assign accept = (state == IDLE) && start && !done;
  assign busy   = (state != IDLE) || done;

  always_comb begin
    state_nxt = state;
    iter_load = 1'b0;
    iter_step = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ALU_Sel == OP_MUL) begin
            state_nxt = MUL_RUN;
            iter_load = 1'b1;
          end else if (ALU_Sel == OP_DIV && B != '0) begin
            state_nxt = DIV_RUN;
            iter_load = 1'b1;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      MUL_RUN, DIV_RUN: begin
        iter_step = 1'b1;
        if (iter_last) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (iter_load),
    .step     (iter_step),
    .div      (ALU_Sel == OP_DIV),
    .a        (A),
    .b        (B),
    .product  (product),
    .quotient (quotient),
    .last     (iter_last)
  );

  always_comb begin
    r     = '0;
    c     = 1'b0;
    v     = 1'b0;
    sh_n  = b_q[SHW-1:0];
    add_s = {1'b0, a_q} + {1'b0, b_q};
    sub_d = {1'b0, a_q} - {1'b0, b_q};
    shl_w = {1'b0, a_q} << sh_n;
    shr_w = {a_q, 1'b0} >> sh_n;
    rol_w = {a_q, a_q} << sh_n;
    ror_w = {a_q, a_q} >> sh_n;
    case (op_q)
      OP_ADD: begin
        r = add_s[WIDTH-1:0];
        c = add_s[WIDTH];
        v = (a_q[MSB] == b_q[MSB]) && (r[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        r = sub_d[WIDTH-1:0];
        c = sub_d[WIDTH];
        v = (a_q[MSB] != b_q[MSB]) && (r[MSB] != a_q[MSB]);
      end
      OP_MUL: begin
        r = product[WIDTH-1:0];
        c = |product[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b_q == '0) begin
          r = '1;
          v = 1'b1;
        end else begin
          r = quotient;
        end
      end
      OP_SHL: begin
        r = shl_w[WIDTH-1:0];
        c = shl_w[WIDTH];
      end
      OP_SHR: begin
        r = shr_w[WIDTH:1];
        c = shr_w[0];
      end
      OP_ROL:  r = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  r = ror_w[WIDTH-1:0];
      OP_AND:  r = a_q & b_q;
      OP_OR:   r = a_q | b_q;
      OP_XOR:  r = a_q ^ b_q;
      OP_NOR:  r = ~(a_q | b_q);
      OP_NAND: r = ~(a_q & b_q);
      OP_XNOR: r = ~(a_q ^ b_q);
      OP_GT:   r = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
      OP_EQ:   r = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      done     <= 1'b0;
      ALU_Out  <= '0;
      Carry    <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FINISH);
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= ALU_Sel;
      end
      // Zero/Negative come from the freshly computed r, not the old ALU_Out.
      if (state == FINISH) begin
        ALU_Out  <= r;
        Carry    <= c;
        Zero     <= (r == '0);
        Negative <= r[MSB];
        Overflow <= v;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases, mid-run start,
// reset abort, and randomized ops against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;
  localparam int M = 256;

  typedef struct {
    int r;
    bit c, z, n, v;
    int lat;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [3:0]   ALU_Sel = '0;
  logic         busy, done, Carry, Zero, Negative, Overflow;
  logic [W-1:0] ALU_Out;

  int   checks = 0;
  int   fails = 0;
  int   acc_wait;
  res_t last_exp;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .busy     (busy),
    .done     (done),
    .ALU_Out  (ALU_Out),
    .Carry    (Carry),
    .Zero     (Zero),
    .Negative (Negative),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic res_t model(input int op, input int a, input int b);
    res_t e;
    int   n, s;
    e.r = 0; e.c = 0; e.v = 0; e.lat = 2;
    n = b % W;
    case (op)
      0: begin
        e.r = (a + b) % M;
        e.c = (a + b) >= M;
        s = to_signed(a) + to_signed(b);
        e.v = (s > M / 2 - 1) || (s < -M / 2);
      end
      1: begin
        e.r = (a - b + M) % M;
        e.c = a < b;
        s = to_signed(a) - to_signed(b);
        e.v = (s > M / 2 - 1) || (s < -M / 2);
      end
      2: begin
        e.r = (a * b) % M;
        e.c = (a * b) >= M;
        e.lat = W + 2;
      end
      3: begin
        if (b == 0) begin
          e.r = M - 1;
          e.v = 1;
        end else begin
          e.r = a / b;
          e.lat = W + 2;
        end
      end
      4: begin
        e.r = (a << n) % M;
        e.c = (n != 0) && (((a >> (W - n)) & 1) == 1);
      end
      5: begin
        e.r = a >> n;
        e.c = (n != 0) && (((a >> (n - 1)) & 1) == 1);
      end
      6:  e.r = ((a << n) | (a >> (W - n))) % M;
      7:  e.r = ((a >> n) | (a << (W - n))) % M;
      8:  e.r = a & b;
      9:  e.r = a | b;
      10: e.r = a ^ b;
      11: e.r = (M - 1) - (a | b);
      12: e.r = (M - 1) - (a & b);
      13: e.r = (M - 1) - (a ^ b);
      14: e.r = (a > b) ? 1 : 0;
      default: e.r = (a == b) ? 1 : 0;
    endcase
    e.z = (e.r == 0);
    e.n = (e.r >= M / 2);
    return e;
  endfunction

  task automatic check_outputs(input string tag, input res_t e);
    check({tag, ".out"}, 32'(ALU_Out), 32'(e.r));
    check({tag, ".carry"}, 32'(Carry), 32'(e.c));
    check({tag, ".zero"}, 32'(Zero), 32'(e.z));
    check({tag, ".neg"}, 32'(Negative), 32'(e.n));
    check({tag, ".ovf"}, 32'(Overflow), 32'(e.v));
  endtask

  // Issues one op, optionally pulses start mid-run, and checks latency, busy and results.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input bit poke);
    res_t e;
    int   cyc, busy_cnt;
    e = model(int'(op), int'(a), int'(b));
    @(negedge clk);
    A = a; B = b; ALU_Sel = op; start = 1'b1;
    acc_wait = 0;
    do begin
      @(posedge clk); #1;
      acc_wait++;
    end while (!busy && acc_wait < 8);
    start = 1'b0;
    check({tag, ".accept"}, 32'(busy), 32'd1);
    cyc = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      if (poke && cyc == 3) begin
        start = 1'b1; ALU_Sel = 4'h0; A = 8'hFF; B = 8'hFF;
      end
      if (cyc == 4) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(e.lat));
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
    check_outputs(tag, e);
    last_exp = e;
  endtask

  // One cycle after done: pulse gone, nothing queued, outputs held.
  task automatic hold_check(input string tag);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check_outputs({tag, ".hold"}, last_exp);
  endtask

  initial begin
    logic [3:0] rop;
    logic [7:0] ra, rb;
    int         cyc;

    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.out", {24'd0, ALU_Out, Carry, Zero, Negative, Overflow} >> 4, 32'd0);
    check("reset.flags", 32'({Carry, Zero, Negative, Overflow}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", 4'h0, 8'h7F, 8'h01, 1'b0);
    hold_check("add_ovf");
    run_op("sub_eq", 4'h1, 8'h05, 8'h05, 1'b0);
    run_op("sub_borrow", 4'h1, 8'h03, 8'h05, 1'b0);
    check("b2b.accept_wait", 32'(acc_wait), 32'd2);
    run_op("mul", 4'h2, 8'h10, 8'h11, 1'b1);
    hold_check("mul");
    run_op("div", 4'h3, 8'hC8, 8'h07, 1'b0);
    run_op("div0", 4'h3, 8'h42, 8'h00, 1'b0);
    run_op("shl", 4'h4, 8'h81, 8'h01, 1'b0);
    run_op("ror", 4'h7, 8'h01, 8'h03, 1'b0);
    run_op("shr0", 4'h5, 8'hA5, 8'h00, 1'b0);
    hold_check("shr0");

    // Reset in the middle of a multiply aborts it with no done.
    @(negedge clk);
    A = 8'h0F; B = 8'h0F; ALU_Sel = 4'h2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.done", 32'(done), 32'd0);
    check("rst_mid.out", 32'(ALU_Out), 32'd0);
    check("rst_mid.flags", 32'({Carry, Zero, Negative, Overflow}), 32'd0);
    cyc = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    check("rst_mid.no_done", 32'(cyc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 4'h0, 8'h01, 8'h01, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (i % 7 == 0) rb = 8'h00;
      run_op($sformatf("rand%0d_op%0h", i, rop), rop, ra, rb, (i % 5 == 1));
      if (i % 6 == 0) hold_check($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal values 4..32, and the value SHALL be a power of two.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port start  input  1  request; accepted only in IDLE.
REQ-005 Port A  input  WIDTH  first operand; sampled at accept.
REQ-006 Port B  input  WIDTH  second operand or shift amount; sampled at accept.
REQ-007 Port ALU_Sel  input  4  opcode; sampled at accept.
REQ-008 Port busy  output  1  high from the cycle after accept until the cycle of done, inclusive.
REQ-009 Port done  output  1  one-cycle pulse; result and flags become valid in this cycle.
REQ-010 Port ALU_Out  output  WIDTH  result register.
REQ-011 Ports Carry, Zero, Negative, Overflow  output  1 each  status flags.

Function
REQ-012 Opcodes SHALL be 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT (unsigned), F EQ.
REQ-013 FSM states SHALL be IDLE, MUL_RUN, DIV_RUN and FINISH.
REQ-014 IDLE with start=1 and opcode MUL SHALL go to MUL_RUN; with opcode DIV and B!=0 it SHALL go to DIV_RUN; with any other opcode, or with DIV and B==0, it SHALL go to FINISH.
REQ-015 MUL_RUN and DIV_RUN SHALL each run exactly WIDTH iteration cycles, tracked by a counter, then go to FINISH.
REQ-016 FINISH SHALL load ALU_Out and all flags, assert done, and return to IDLE.
REQ-017 Latency: done SHALL be asserted 2 cycles after accept for single-cycle ops and for DIV with B==0, and WIDTH+2 cycles after accept for MUL and for DIV with B!=0.
REQ-018 start while busy SHALL be ignored with no queueing; start in the FINISH cycle SHALL also be ignored; back-to-back accept SHALL be possible in the cycle after done.
REQ-019 ALU_Out and the flags SHALL hold their values between done pulses.
REQ-020 ADD: R=(A+B) mod 2^WIDTH; Carry=bit WIDTH of the sum; Overflow=(A[msb]==B[msb]) && (R[msb]!=A[msb]).
REQ-021 SUB: R=(A-B) mod 2^WIDTH; Carry=1 iff A<B unsigned (borrow); Overflow=(A[msb]!=B[msb]) && (R[msb]!=A[msb]).
REQ-022 MUL: unsigned iterative shift-add; R=low WIDTH bits of the product; Carry=1 iff the high WIDTH bits are nonzero.
REQ-023 DIV: unsigned restoring division; R=quotient; the remainder SHALL be discarded.
REQ-024 DIV with B==0: R=all ones; Overflow=1; Carry=0.
REQ-025 Shifts and rotates: amount n=B[log2(WIDTH)-1:0].
REQ-026 SHL/SHR: logical shift by n; Carry=last bit shifted out; Carry=0 when n=0.
REQ-027 ROL/ROR: rotate by n; Carry=0.
REQ-028 Logic ops SHALL be bitwise over WIDTH bits.
REQ-029 GT/EQ: R=1 when true, else 0.
REQ-030 Carry and Overflow SHALL be 0 for every op not specified above.
REQ-031 Zero=(R==0) and Negative=R[msb], both computed from the new result R in the same FINISH cycle, never from the previous ALU_Out.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, counter 0, busy 0, done 0, ALU_Out 0, and all flags 0.
REQ-033 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-034 Operation after reset release SHALL begin with the first start sampled high on a rising edge while rst_n is high.

Structure
REQ-035 Package alu_seq_pkg SHALL hold the opcode constants and the FSM state type.
REQ-036 Sub-module alu_seq_iter SHALL hold the iterative MUL/DIV datapath: accumulator, shift registers, and iteration counter, with load/step inputs and product/quotient outputs.
REQ-037 All other ops SHALL be combinational inside alu_seq, computed from the latched operands.

Verification
REQ-038 WIDTH=8, ADD A=0x7F B=0x01 -> done at accept+2, ALU_Out=0x80, Overflow=1, Negative=1, Carry=0, Zero=0.
REQ-039 WIDTH=8, SUB A=0x05 B=0x05 -> ALU_Out=0x00, Zero=1, Carry=0; then SUB A=0x03 B=0x05 -> 0xFE, Carry=1, Negative=1.
REQ-040 WIDTH=8, MUL A=0x10 B=0x11 -> done at accept+10, ALU_Out=0x10, Carry=1, busy high for 10 cycles; a start pulsed mid-run is ignored.
REQ-041 WIDTH=8, DIV A=0xC8 B=0x07 -> done at accept+10, ALU_Out=0x1C; DIV A=0x42 B=0x00 -> done at accept+2, ALU_Out=0xFF, Overflow=1.
REQ-042 WIDTH=8, SHL A=0x81 B=0x01 -> 0x02, Carry=1; ROR A=0x01 B=0x03 -> 0x20, Carry=0; SHR with B=0x00 -> ALU_Out=A, Carry=0.
REQ-043 WIDTH=8, rst_n low at cycle 4 of a MUL -> all outputs 0 immediately, no done pulse; after release a new ADD 0x01+0x01 completes with ALU_Out=0x02.
